// File: rtl/c5_ctrl_pkg.sv
// Shared LeNet constants and the C5 controller state encoding.
package c5_ctrl_pkg;

  localparam int unsigned C5_N_IN    = 400;
  localparam int unsigned C5_N_OUT   = 120;
  localparam int unsigned W5_AW      = 9;
  localparam int unsigned C5_ROM_LAT = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } c5_state_e;

endpackage

// File: rtl/c5_ctrl_lat_pipe.sv
// Fixed-depth shift register that aligns control bits with a registered ROM read.
module lat_pipe #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [DEPTH-1:0][WIDTH-1:0] r_stage;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/c5_ctrl.sv
// C5 pass sequencer: walks weight/feature addresses and strobes the accumulators.
module c5_ctrl
  import c5_ctrl_pkg::*;
#(
  parameter int unsigned N_IN    = C5_N_IN,
  parameter int unsigned AW      = W5_AW,
  parameter int unsigned ROM_LAT = C5_ROM_LAT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stall,
  output logic [AW-1:0] w5_raddr,
  output logic [AW-1:0] s4_raddr,
  output logic          acc_clr,
  output logic          acc_en,
  output logic          acc_last,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(N_IN - 1);

  c5_state_e     r_state;
  c5_state_e     w_next;
  logic [AW-1:0] r_addr;
  logic          w_issue;
  logic          w_is_last;
  logic [1:0]    w_pipe_q;

  assign w_issue   = (r_state == ST_RUN) && !stall;
  assign w_is_last = (r_addr == LAST_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    acc_clr = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) w_next = ST_CLR;
      end
      ST_CLR: begin
        acc_clr = 1'b1;
        w_next  = ST_RUN;
      end
      ST_RUN: begin
        if (w_issue && w_is_last) w_next = ST_DRAIN;
      end
      // Leave only once the final term has reached the accumulators.
      ST_DRAIN: begin
        if (w_pipe_q[1]) w_next = ST_DONE;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // The counter parks on the last address and is only cleared on the way back to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
    end else if (w_next == ST_IDLE) begin
      r_addr <= '0;
    end else if (w_issue && !w_is_last) begin
      r_addr <= r_addr + 1'b1;
    end
  end

  lat_pipe #(
    .DEPTH(ROM_LAT),
    .WIDTH(2)
  ) u_lat_pipe (
    .clk  (clk),
    .rst_n(rst_n),
    .i_d  ({w_issue && w_is_last, w_issue}),
    .o_q  (w_pipe_q)
  );

  assign acc_en   = w_pipe_q[0];
  assign acc_last = w_pipe_q[1];
  assign w5_raddr = r_addr;
  assign s4_raddr = r_addr;

endmodule

// File: tb/tb_c5_ctrl.sv
// Scoreboard bench for c5_ctrl: three configurations, per-cycle history plus term queues.
module tb_c5_ctrl;

  localparam int AW   = 9;
  localparam int HMAX = 420;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall = 1'b0;
  logic start_req = 1'b0;
  int   sel = 0;

  logic start_a, start_c, start_n;
  assign start_a = start_req && (sel == 0);
  assign start_c = start_req && (sel == 1);
  assign start_n = start_req && (sel == 2);

  logic [AW-1:0] w5_raddr_a, s4_raddr_a, w5_raddr_c, s4_raddr_c, w5_raddr_n, s4_raddr_n;
  logic acc_clr_a, acc_en_a, acc_last_a, busy_a, done_a;
  logic acc_clr_c, acc_en_c, acc_last_c, busy_c, done_c;
  logic acc_clr_n, acc_en_n, acc_last_n, busy_n, done_n;

  c5_ctrl #(.N_IN(400), .AW(AW), .ROM_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .stall(stall),
    .w5_raddr(w5_raddr_a), .s4_raddr(s4_raddr_a), .acc_clr(acc_clr_a),
    .acc_en(acc_en_a), .acc_last(acc_last_a), .busy(busy_a), .done(done_a));

  c5_ctrl #(.N_IN(400), .AW(AW), .ROM_LAT(3)) dut_lat3 (
    .clk(clk), .rst_n(rst_n), .start(start_c), .stall(stall),
    .w5_raddr(w5_raddr_c), .s4_raddr(s4_raddr_c), .acc_clr(acc_clr_c),
    .acc_en(acc_en_c), .acc_last(acc_last_c), .busy(busy_c), .done(done_c));

  c5_ctrl #(.N_IN(1), .AW(AW), .ROM_LAT(1)) dut_n1 (
    .clk(clk), .rst_n(rst_n), .start(start_n), .stall(stall),
    .w5_raddr(w5_raddr_n), .s4_raddr(s4_raddr_n), .acc_clr(acc_clr_n),
    .acc_en(acc_en_n), .acc_last(acc_last_n), .busy(busy_n), .done(done_n));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model ROMs: data equals address, with each instance's read latency.
  logic [AW-1:0] rom_a, rom_n, rc1, rc2, rc3;
  always @(posedge clk) begin
    rom_a <= w5_raddr_a;
    rom_n <= w5_raddr_n;
    rc1   <= w5_raddr_c;
    rc2   <= rc1;
    rc3   <= rc2;
  end

  int checks = 0;
  int errors = 0;
  int q_a[$];
  int q_c[$];
  int q_n[$];

  bit en_h   [HMAX];
  bit last_h [HMAX];
  bit clr_h  [HMAX];
  bit busy_h [HMAX];
  bit done_h [HMAX];
  int addr_h [HMAX];
  int s4_bad;

  logic          m_en, m_last, m_clr, m_busy, m_done;
  logic [AW-1:0] m_addr, m_s4;
  always_comb begin
    m_en = acc_en_a; m_last = acc_last_a; m_clr = acc_clr_a;
    m_busy = busy_a; m_done = done_a; m_addr = w5_raddr_a; m_s4 = s4_raddr_a;
    case (sel)
      1: begin
        m_en = acc_en_c; m_last = acc_last_c; m_clr = acc_clr_c;
        m_busy = busy_c; m_done = done_c; m_addr = w5_raddr_c; m_s4 = s4_raddr_c;
      end
      2: begin
        m_en = acc_en_n; m_last = acc_last_n; m_clr = acc_clr_n;
        m_busy = busy_n; m_done = done_n; m_addr = w5_raddr_n; m_s4 = s4_raddr_n;
      end
      default: ;
    endcase
  end

  // Scoreboard: each acc_en must consume the next expected term, in order.
  always @(negedge clk) begin
    int e;
    #1;
    if (acc_en_a === 1'b1) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++; $display("FAIL sb_a_extra: acc_en with data %0d, expected no term", rom_a);
      end else begin
        e = q_a.pop_front();
        if (rom_a !== 9'(e) || acc_last_a !== (e == 399)) begin
          errors++;
          $display("FAIL sb_a: got data %0d last %0b, expected data %0d last %0b", rom_a, acc_last_a, e, (e == 399));
        end
      end
    end
    if (acc_en_c === 1'b1) begin
      checks++;
      if (q_c.size() == 0) begin
        errors++; $display("FAIL sb_c_extra: acc_en with data %0d, expected no term", rc3);
      end else begin
        e = q_c.pop_front();
        if (rc3 !== 9'(e) || acc_last_c !== (e == 399)) begin
          errors++;
          $display("FAIL sb_c: got data %0d last %0b, expected data %0d last %0b", rc3, acc_last_c, e, (e == 399));
        end
      end
    end
    if (acc_en_n === 1'b1) begin
      checks++;
      if (q_n.size() == 0) begin
        errors++; $display("FAIL sb_n_extra: acc_en with data %0d, expected no term", rom_n);
      end else begin
        e = q_n.pop_front();
        if (rom_n !== 9'(e) || acc_last_n !== 1'b1) begin
          errors++;
          $display("FAIL sb_n: got data %0d last %0b, expected data %0d last 1", rom_n, acc_last_n, e);
        end
      end
    end
  end

  function automatic int cnt(input int kind, input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++) begin
      case (kind)
        0: n += int'(en_h[c]);
        1: n += int'(last_h[c]);
        2: n += int'(done_h[c]);
        3: n += int'(busy_h[c]);
        default: n += int'(clr_h[c]);
      endcase
    end
    return n;
  endfunction

  // Runs one pass on the selected instance; index c = cycle number with start sampled at cycle 0.
  task automatic rec(input int which, input int n, input int s_lo, input int s_hi,
                     input int x1, input int x2, input int r_at, input int ncyc);
    sel = which;
    s4_bad = 0;
    for (int i = 0; i < HMAX; i++) begin
      en_h[i] = 0; last_h[i] = 0; clr_h[i] = 0; busy_h[i] = 0; done_h[i] = 0; addr_h[i] = -1;
    end
    for (int i = 0; i < n; i++) begin
      case (which)
        0: q_a.push_back(i);
        1: q_c.push_back(i);
        default: q_n.push_back(i);
      endcase
    end
    @(negedge clk); start_req = 1'b1;
    @(negedge clk); start_req = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      stall     = (c >= s_lo) && (c <= s_hi);
      start_req = (c == x1) || (c == x2);
      if (r_at > 0 && c == r_at)     rst_n = 1'b0;
      if (r_at > 0 && c == r_at + 2) rst_n = 1'b1;
      #1;
      en_h[c] = m_en; last_h[c] = m_last; clr_h[c] = m_clr;
      busy_h[c] = m_busy; done_h[c] = m_done; addr_h[c] = int'(m_addr);
      if (m_s4 !== m_addr) s4_bad++;
      @(negedge clk);
    end
    start_req = 1'b0;
    stall = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_req = 1'b0; stall = 1'b0; sel = 0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({acc_clr_a, acc_en_a, acc_last_a, busy_a, done_a} !== 5'b0) begin
      errors++; $display("FAIL rst_flags_a: got %b expected 00000", {acc_clr_a, acc_en_a, acc_last_a, busy_a, done_a});
    end
    checks++;
    if (w5_raddr_a !== '0 || s4_raddr_a !== '0) begin
      errors++; $display("FAIL rst_addr_a: got %0d/%0d expected 0/0", w5_raddr_a, s4_raddr_a);
    end
    checks++;
    if ({acc_clr_c, acc_en_c, acc_last_c, busy_c, done_c, acc_en_n, acc_last_n, busy_n, done_n} !== 9'b0) begin
      errors++; $display("FAIL rst_flags_cn: got %b expected 000000000",
                         {acc_clr_c, acc_en_c, acc_last_c, busy_c, done_c, acc_en_n, acc_last_n, busy_n, done_n});
    end
    start_req = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (busy_a !== 1'b0) begin
      errors++; $display("FAIL rst_start_ignored: busy got %b expected 0", busy_a);
    end
    start_req = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (busy_a !== 1'b0) begin
      errors++; $display("FAIL rst_no_latched_start: busy got %b expected 0", busy_a);
    end
  endtask

  task automatic test_nominal();
    int mx = 0;
    rec(0, 400, -1, -1, -1, -1, -1, 406);
    for (int c = 1; c <= 406; c++) if (addr_h[c] > mx) mx = addr_h[c];
    checks++; if (clr_h[1] !== 1'b1) begin errors++; $display("FAIL nom_clr: got %b expected 1", clr_h[1]); end
    checks++; if (cnt(4, 1, 406) != 1) begin errors++; $display("FAIL nom_clr_count: got %0d expected 1", cnt(4, 1, 406)); end
    checks++; if (en_h[2] !== 1'b0) begin errors++; $display("FAIL nom_en_c2: got %b expected 0", en_h[2]); end
    checks++; if (en_h[3] !== 1'b1) begin errors++; $display("FAIL nom_en_c3: got %b expected 1", en_h[3]); end
    checks++; if (en_h[402] !== 1'b1) begin errors++; $display("FAIL nom_en_c402: got %b expected 1", en_h[402]); end
    checks++; if (en_h[403] !== 1'b0) begin errors++; $display("FAIL nom_en_c403: got %b expected 0", en_h[403]); end
    checks++; if (cnt(0, 1, 406) != 400) begin errors++; $display("FAIL nom_en_count: got %0d expected 400", cnt(0, 1, 406)); end
    checks++; if (last_h[402] !== 1'b1) begin errors++; $display("FAIL nom_last: got %b expected 1", last_h[402]); end
    checks++; if (cnt(1, 1, 406) != 1) begin errors++; $display("FAIL nom_last_count: got %0d expected 1", cnt(1, 1, 406)); end
    checks++; if (done_h[403] !== 1'b1) begin errors++; $display("FAIL nom_done: got %b expected 1", done_h[403]); end
    checks++; if (cnt(2, 1, 406) != 1) begin errors++; $display("FAIL nom_done_count: got %0d expected 1", cnt(2, 1, 406)); end
    checks++; if (cnt(3, 1, 403) != 403) begin errors++; $display("FAIL nom_busy_high: got %0d expected 403", cnt(3, 1, 403)); end
    checks++; if (busy_h[404] !== 1'b0) begin errors++; $display("FAIL nom_busy_low: got %b expected 0", busy_h[404]); end
    checks++; if (addr_h[2] != 0) begin errors++; $display("FAIL nom_addr_first: got %0d expected 0", addr_h[2]); end
    checks++; if (addr_h[200] != 198) begin errors++; $display("FAIL nom_addr_mid: got %0d expected 198", addr_h[200]); end
    checks++; if (addr_h[401] != 399) begin errors++; $display("FAIL nom_addr_last: got %0d expected 399", addr_h[401]); end
    checks++; if (addr_h[404] != 0) begin errors++; $display("FAIL nom_addr_idle: got %0d expected 0", addr_h[404]); end
    checks++; if (mx != 399) begin errors++; $display("FAIL nom_addr_max: got %0d expected 399", mx); end
    checks++; if (s4_bad != 0) begin errors++; $display("FAIL nom_s4_eq: got %0d mismatching cycles expected 0", s4_bad); end
    checks++; if (q_a.size() != 0) begin errors++; $display("FAIL nom_sb_left: got %0d terms expected 0", q_a.size()); end
  endtask

  task automatic test_stall();
    rec(0, 400, 10, 14, -1, -1, -1, 410);
    for (int c = 10; c <= 14; c++) begin
      checks++;
      if (addr_h[c] != 8) begin errors++; $display("FAIL stall_addr_hold c%0d: got %0d expected 8", c, addr_h[c]); end
    end
    for (int c = 11; c <= 15; c++) begin
      checks++;
      if (en_h[c] !== 1'b0) begin errors++; $display("FAIL stall_bubble c%0d: got %b expected 0", c, en_h[c]); end
    end
    checks++; if (en_h[10] !== 1'b1) begin errors++; $display("FAIL stall_en_c10: got %b expected 1", en_h[10]); end
    checks++; if (en_h[16] !== 1'b1) begin errors++; $display("FAIL stall_en_c16: got %b expected 1", en_h[16]); end
    checks++; if (cnt(0, 1, 410) != 400) begin errors++; $display("FAIL stall_en_count: got %0d expected 400", cnt(0, 1, 410)); end
    checks++; if (done_h[408] !== 1'b1) begin errors++; $display("FAIL stall_done: got %b expected 1", done_h[408]); end
    checks++; if (cnt(2, 1, 410) != 1) begin errors++; $display("FAIL stall_done_count: got %0d expected 1", cnt(2, 1, 410)); end
    checks++; if (busy_h[409] !== 1'b0) begin errors++; $display("FAIL stall_busy_low: got %b expected 0", busy_h[409]); end
    checks++; if (q_a.size() != 0) begin errors++; $display("FAIL stall_sb_left: got %0d terms expected 0", q_a.size()); end
  endtask

  task automatic test_ignored_start();
    rec(0, 400, -1, -1, 50, 403, -1, 410);
    checks++; if (cnt(2, 1, 410) != 1) begin errors++; $display("FAIL ign_done_count: got %0d expected 1", cnt(2, 1, 410)); end
    checks++; if (done_h[403] !== 1'b1) begin errors++; $display("FAIL ign_done: got %b expected 1", done_h[403]); end
    checks++; if (cnt(3, 404, 410) != 0) begin errors++; $display("FAIL ign_no_restart: busy cycles got %0d expected 0", cnt(3, 404, 410)); end
    checks++; if (cnt(4, 2, 410) != 0) begin errors++; $display("FAIL ign_no_clr: got %0d expected 0", cnt(4, 2, 410)); end
    checks++; if (cnt(0, 1, 410) != 400) begin errors++; $display("FAIL ign_en_count: got %0d expected 400", cnt(0, 1, 410)); end
    checks++; if (q_a.size() != 0) begin errors++; $display("FAIL ign_sb_left: got %0d terms expected 0", q_a.size()); end
  endtask

  task automatic test_reset_mid();
    rec(0, 400, -1, -1, -1, -1, 200, 206);
    checks++; if (busy_h[199] !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %b expected 1", busy_h[199]); end
    checks++;
    if ({clr_h[200], en_h[200], last_h[200], busy_h[200], done_h[200]} !== 5'b0) begin
      errors++; $display("FAIL rmid_flags: got %b expected 00000", {clr_h[200], en_h[200], last_h[200], busy_h[200], done_h[200]});
    end
    checks++; if (addr_h[200] != 0) begin errors++; $display("FAIL rmid_addr: got %0d expected 0", addr_h[200]); end
    checks++; if (cnt(2, 1, 206) != 0) begin errors++; $display("FAIL rmid_no_done: got %0d expected 0", cnt(2, 1, 206)); end
    checks++; if (cnt(3, 200, 206) != 0) begin errors++; $display("FAIL rmid_stays_idle: busy cycles got %0d expected 0", cnt(3, 200, 206)); end
    q_a.delete();
    rec(0, 400, -1, -1, -1, -1, -1, 406);
    checks++; if (addr_h[2] != 0) begin errors++; $display("FAIL rmid_rerun_addr: got %0d expected 0", addr_h[2]); end
    checks++; if (cnt(0, 1, 406) != 400) begin errors++; $display("FAIL rmid_rerun_count: got %0d expected 400", cnt(0, 1, 406)); end
    checks++; if (done_h[403] !== 1'b1) begin errors++; $display("FAIL rmid_rerun_done: got %b expected 1", done_h[403]); end
    checks++; if (q_a.size() != 0) begin errors++; $display("FAIL rmid_sb_left: got %0d terms expected 0", q_a.size()); end
  endtask

  task automatic test_latency();
    rec(1, 400, -1, -1, -1, -1, -1, 408);
    checks++; if (en_h[4] !== 1'b0) begin errors++; $display("FAIL lat3_en_c4: got %b expected 0", en_h[4]); end
    checks++; if (en_h[5] !== 1'b1) begin errors++; $display("FAIL lat3_en_c5: got %b expected 1", en_h[5]); end
    checks++; if (en_h[404] !== 1'b1) begin errors++; $display("FAIL lat3_en_c404: got %b expected 1", en_h[404]); end
    checks++; if (last_h[404] !== 1'b1) begin errors++; $display("FAIL lat3_last: got %b expected 1", last_h[404]); end
    checks++; if (done_h[405] !== 1'b1) begin errors++; $display("FAIL lat3_done: got %b expected 1", done_h[405]); end
    checks++; if (cnt(2, 1, 408) != 1) begin errors++; $display("FAIL lat3_done_count: got %0d expected 1", cnt(2, 1, 408)); end
    checks++; if (cnt(0, 1, 408) != 400) begin errors++; $display("FAIL lat3_en_count: got %0d expected 400", cnt(0, 1, 408)); end
    checks++; if (busy_h[406] !== 1'b0) begin errors++; $display("FAIL lat3_busy_low: got %b expected 0", busy_h[406]); end
    checks++; if (q_c.size() != 0) begin errors++; $display("FAIL lat3_sb_left: got %0d terms expected 0", q_c.size()); end
  endtask

  task automatic test_n1();
    rec(2, 1, -1, -1, -1, -1, -1, 8);
    checks++; if (addr_h[2] != 0) begin errors++; $display("FAIL n1_addr: got %0d expected 0", addr_h[2]); end
    checks++; if (en_h[3] !== 1'b1 || last_h[3] !== 1'b1) begin
      errors++; $display("FAIL n1_en_last: got en %b last %b expected 1 1", en_h[3], last_h[3]);
    end
    checks++; if (cnt(0, 1, 8) != 1) begin errors++; $display("FAIL n1_en_count: got %0d expected 1", cnt(0, 1, 8)); end
    checks++; if (done_h[4] !== 1'b1) begin errors++; $display("FAIL n1_done: got %b expected 1", done_h[4]); end
    checks++; if (cnt(2, 1, 8) != 1) begin errors++; $display("FAIL n1_done_count: got %0d expected 1", cnt(2, 1, 8)); end
    checks++; if (busy_h[5] !== 1'b0) begin errors++; $display("FAIL n1_busy_low: got %b expected 0", busy_h[5]); end
    checks++; if (q_n.size() != 0) begin errors++; $display("FAIL n1_sb_left: got %0d terms expected 0", q_n.size()); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stall();
    test_ignored_start();
    test_reset_mid();
    test_latency();
    test_n1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
